// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM port scheduler.
package sdram_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } sched_state_t;

  localparam int ASIZE_DEF = 23;
  localparam int LEN_W_DEF = 9;

  // Width of an index able to address n ports (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_addr_ptr.sv
// Per-port wrap-around SDRAM address pointer.
// While at_min is set the pointer follows MIN directly, so reset, reload and
// wrap all land on the region start without needing a reset-time copy of MIN.
module sdram_addr_ptr #(
  parameter int ASIZE = 23,
  parameter int LEN_W = 9
) (
  input  logic             CTRL_CLK,
  input  logic             RESET_N,
  input  logic [ASIZE-1:0] MIN,
  input  logic [ASIZE-1:0] MAX,
  input  logic [LEN_W-1:0] LEN,
  input  logic             LOAD,
  input  logic             ADV,
  output logic [ASIZE-1:0] PTR
);

  logic             at_min;
  logic [ASIZE-1:0] ptr_q;
  logic [ASIZE:0]   limit;
  logic             wrap;

  assign PTR = at_min ? MIN : ptr_q;

  // Wrap when ptr >= MAX-LEN; a negative MAX-LEN (MAX<LEN) always wraps.
  always_comb begin
    limit = {1'b0, MAX} - (ASIZE+1)'(LEN);
    wrap  = limit[ASIZE] || ({1'b0, PTR} >= limit);
  end

  // Pointer state: reload beats advance; advance either steps or wraps to MIN.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      at_min <= 1'b1;
      ptr_q  <= '0;
    end else if (LOAD) begin
      at_min <= 1'b1;
    end else if (ADV) begin
      if (wrap) begin
        at_min <= 1'b1;
      end else begin
        at_min <= 1'b0;
        ptr_q  <= PTR + ASIZE'(LEN);
      end
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Arbitrates SDRAM page bursts between NW write-FIFO ports and NR read-FIFO
// ports and owns each port's wrap-around address pointer.
//
// Handshake with the command sequencer: REQ_WR/REQ_RD is a level request that,
// once raised, stays high with REQ_ADDR/REQ_LEN/GNT_* stable until the
// sequencer returns a one-cycle XFER_DONE; the request then drops on the next
// edge and a dead HOLD cycle follows so the sequencer observes the falling edge
// before any new request can rise.
module sdram_port_scheduler
  import sdram_pkg::*;
#(
  parameter int NW    = 2,
  parameter int NR    = 2,
  parameter int ASIZE = ASIZE_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int LVL_W = 16,
  parameter int RR_EN = 1
) (
  input  logic               CTRL_CLK,
  input  logic               RESET_N,
  input  logic [NW*LVL_W-1:0] WR_LVL,
  input  logic [NW*LEN_W-1:0] WR_LEN,
  input  logic [NW*ASIZE-1:0] WR_MIN,
  input  logic [NW*ASIZE-1:0] WR_MAX,
  input  logic [NW-1:0]       WR_LOAD,
  input  logic [NR*LVL_W-1:0] RD_LVL,
  input  logic [NR*LEN_W-1:0] RD_LEN,
  input  logic [NR*ASIZE-1:0] RD_MIN,
  input  logic [NR*ASIZE-1:0] RD_MAX,
  input  logic [NR-1:0]       RD_LOAD,
  input  logic               SEQ_IDLE,
  input  logic               XFER_DONE,
  output logic               REQ_WR,
  output logic               REQ_RD,
  output logic [ASIZE-1:0]   REQ_ADDR,
  output logic [LEN_W-1:0]   REQ_LEN,
  output logic [NW-1:0]      GNT_WR,
  output logic [NR-1:0]      GNT_RD,
  output sched_state_t       DBG_STATE
);

  localparam int NP = NW + NR;
  localparam int PW = idx_w(NP);
  localparam int CW = (LVL_W > LEN_W) ? LVL_W : LEN_W;

  // Ports flattened in arbitration order W0..W(NW-1), R0..R(NR-1).
  logic [LEN_W-1:0] len_a [NP];
  logic [ASIZE-1:0] min_a [NP];
  logic [ASIZE-1:0] max_a [NP];
  logic [ASIZE-1:0] ptr_a [NP];
  logic [NP-1:0]    load_a;
  logic [NP-1:0]    elig;
  logic [NP-1:0]    adv;

  sched_state_t state_q, state_d;
  logic         grant_set, grant_clr;
  logic         any_elig;
  logic [PW-1:0] win_d, win_q, rr_q, rr_next, start;
  logic [PW:0]   idx;
  logic [NW-1:0] gnt_wr_d;
  logic [NR-1:0] gnt_rd_d;
  logic          burst_loaded;

  for (genvar gi = 0; gi < NW; gi++) begin : g_wr
    assign len_a[gi]  = WR_LEN[gi*LEN_W +: LEN_W];
    assign min_a[gi]  = WR_MIN[gi*ASIZE +: ASIZE];
    assign max_a[gi]  = WR_MAX[gi*ASIZE +: ASIZE];
    assign load_a[gi] = WR_LOAD[gi];
    // A write port needs a full burst waiting in its FIFO.
    assign elig[gi] = (CW'(WR_LVL[gi*LVL_W +: LVL_W]) >= CW'(len_a[gi])) &&
                      (len_a[gi] != '0) && !WR_LOAD[gi];
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    assign len_a[NW+gi]  = RD_LEN[gi*LEN_W +: LEN_W];
    assign min_a[NW+gi]  = RD_MIN[gi*ASIZE +: ASIZE];
    assign max_a[NW+gi]  = RD_MAX[gi*ASIZE +: ASIZE];
    assign load_a[NW+gi] = RD_LOAD[gi];
    // A read port is eligible while its fill level is below one burst.
    assign elig[NW+gi] = (CW'(RD_LVL[gi*LVL_W +: LVL_W]) < CW'(len_a[NW+gi])) &&
                         (len_a[NW+gi] != '0) && !RD_LOAD[gi];
  end

  for (genvar gp = 0; gp < NP; gp++) begin : g_ptr
    // A reload seen during this port's burst suppresses the closing advance.
    assign adv[gp] = grant_clr && (win_q == PW'(gp)) && !burst_loaded;
    sdram_addr_ptr #(.ASIZE(ASIZE), .LEN_W(LEN_W)) u_ptr (
      .CTRL_CLK (CTRL_CLK),
      .RESET_N  (RESET_N),
      .MIN      (min_a[gp]),
      .MAX      (max_a[gp]),
      .LEN      (len_a[gp]),
      .LOAD     (load_a[gp]),
      .ADV      (adv[gp]),
      .PTR      (ptr_a[gp])
    );
  end

  assign start = (RR_EN != 0) ? rr_q : '0;

  // Rotating priority encoder: first eligible port at or after start.
  always_comb begin
    any_elig = 1'b0;
    win_d    = '0;
    idx      = '0;
    for (int k = 0; k < NP; k++) begin
      idx = {1'b0, start} + (PW+1)'(k);
      if (idx >= (PW+1)'(NP)) idx = idx - (PW+1)'(NP);
      if (!any_elig && elig[idx[PW-1:0]]) begin
        any_elig = 1'b1;
        win_d    = idx[PW-1:0];
      end
    end
  end

  // One-hot grant decode and next round-robin start for the candidate winner.
  always_comb begin
    gnt_wr_d = '0;
    gnt_rd_d = '0;
    for (int i = 0; i < NW; i++) gnt_wr_d[i] = (win_d == PW'(i));
    for (int j = 0; j < NR; j++) gnt_rd_d[j] = (win_d == PW'(NW + j));
    rr_next = (win_d == PW'(NP - 1)) ? '0 : win_d + PW'(1);
  end

  // FSM state register.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant_set) state_d = ST_GRANT;
      ST_GRANT: if (XFER_DONE) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: when a grant is taken and when it is released.
  always_comb begin
    grant_set = (state_q == ST_IDLE) && SEQ_IDLE && any_elig;
    grant_clr = (state_q == ST_GRANT) && XFER_DONE;
  end

  // Registered request/grant outputs, held stable for the whole burst.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      REQ_WR   <= 1'b0;
      REQ_RD   <= 1'b0;
      REQ_ADDR <= '0;
      REQ_LEN  <= '0;
      GNT_WR   <= '0;
      GNT_RD   <= '0;
      win_q    <= '0;
      rr_q     <= '0;
    end else if (grant_set) begin
      REQ_WR   <= (win_d < PW'(NW));
      REQ_RD   <= (win_d >= PW'(NW));
      REQ_ADDR <= ptr_a[win_d];
      REQ_LEN  <= len_a[win_d];
      GNT_WR   <= gnt_wr_d;
      GNT_RD   <= gnt_rd_d;
      win_q    <= win_d;
      if (RR_EN != 0) rr_q <= rr_next;
    end else if (grant_clr) begin
      REQ_WR   <= 1'b0;
      REQ_RD   <= 1'b0;
      REQ_ADDR <= '0;
      REQ_LEN  <= '0;
      GNT_WR   <= '0;
      GNT_RD   <= '0;
    end
  end

  // Remember a reload of the granted port until its burst closes.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N)                                    burst_loaded <= 1'b0;
    else if (grant_clr)                              burst_loaded <= 1'b0;
    else if (state_q == ST_GRANT && load_a[win_q])   burst_loaded <= 1'b1;
  end

  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Self-checking bench for sdram_port_scheduler: a round-robin instance and a
// fixed-priority instance share all inputs; a behavioural port/pointer model
// predicts winners and burst addresses.
module tb_sdram_port_scheduler;
  import sdram_pkg::*;

  localparam int NW = 2, NR = 2, NP = 4, ASIZE = 23, LEN_W = 9, LVL_W = 16;

  // ---------------- clock / reset ----------------
  logic CTRL_CLK = 1'b0;
  logic RESET_N  = 1'b0;
  always #5 CTRL_CLK = ~CTRL_CLK;

  logic [NW*LVL_W-1:0] WR_LVL;
  logic [NW*LEN_W-1:0] WR_LEN;
  logic [NW*ASIZE-1:0] WR_MIN, WR_MAX;
  logic [NW-1:0]       WR_LOAD;
  logic [NR*LVL_W-1:0] RD_LVL;
  logic [NR*LEN_W-1:0] RD_LEN;
  logic [NR*ASIZE-1:0] RD_MIN, RD_MAX;
  logic [NR-1:0]       RD_LOAD;
  logic                SEQ_IDLE, XFER_DONE;

  logic req_wr, req_rd;
  logic [ASIZE-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic [NW-1:0] gnt_wr;
  logic [NR-1:0] gnt_rd;
  sched_state_t dbg_state;

  logic f_req_wr, f_req_rd;
  logic [ASIZE-1:0] f_req_addr;
  logic [LEN_W-1:0] f_req_len;
  logic [NW-1:0] f_gnt_wr;
  logic [NR-1:0] f_gnt_rd;
  sched_state_t f_dbg_state;

  sdram_port_scheduler #(.NW(NW), .NR(NR), .ASIZE(ASIZE), .LEN_W(LEN_W), .LVL_W(LVL_W), .RR_EN(1)) dut (
    .CTRL_CLK(CTRL_CLK), .RESET_N(RESET_N),
    .WR_LVL(WR_LVL), .WR_LEN(WR_LEN), .WR_MIN(WR_MIN), .WR_MAX(WR_MAX), .WR_LOAD(WR_LOAD),
    .RD_LVL(RD_LVL), .RD_LEN(RD_LEN), .RD_MIN(RD_MIN), .RD_MAX(RD_MAX), .RD_LOAD(RD_LOAD),
    .SEQ_IDLE(SEQ_IDLE), .XFER_DONE(XFER_DONE),
    .REQ_WR(req_wr), .REQ_RD(req_rd), .REQ_ADDR(req_addr), .REQ_LEN(req_len),
    .GNT_WR(gnt_wr), .GNT_RD(gnt_rd), .DBG_STATE(dbg_state));

  sdram_port_scheduler #(.NW(NW), .NR(NR), .ASIZE(ASIZE), .LEN_W(LEN_W), .LVL_W(LVL_W), .RR_EN(0)) dut_fp (
    .CTRL_CLK(CTRL_CLK), .RESET_N(RESET_N),
    .WR_LVL(WR_LVL), .WR_LEN(WR_LEN), .WR_MIN(WR_MIN), .WR_MAX(WR_MAX), .WR_LOAD(WR_LOAD),
    .RD_LVL(RD_LVL), .RD_LEN(RD_LEN), .RD_MIN(RD_MIN), .RD_MAX(RD_MAX), .RD_LOAD(RD_LOAD),
    .SEQ_IDLE(SEQ_IDLE), .XFER_DONE(XFER_DONE),
    .REQ_WR(f_req_wr), .REQ_RD(f_req_rd), .REQ_ADDR(f_req_addr), .REQ_LEN(f_req_len),
    .GNT_WR(f_gnt_wr), .GNT_RD(f_gnt_rd), .DBG_STATE(f_dbg_state));

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  longint m_ptr [NP];
  int     m_rr;

  function automatic int p_lvl(int p);
    return (p < NW) ? int'(WR_LVL[p*LVL_W +: LVL_W]) : int'(RD_LVL[(p-NW)*LVL_W +: LVL_W]);
  endfunction
  function automatic int p_len(int p);
    return (p < NW) ? int'(WR_LEN[p*LEN_W +: LEN_W]) : int'(RD_LEN[(p-NW)*LEN_W +: LEN_W]);
  endfunction
  function automatic longint p_min(int p);
    return (p < NW) ? longint'(WR_MIN[p*ASIZE +: ASIZE]) : longint'(RD_MIN[(p-NW)*ASIZE +: ASIZE]);
  endfunction
  function automatic longint p_max(int p);
    return (p < NW) ? longint'(WR_MAX[p*ASIZE +: ASIZE]) : longint'(RD_MAX[(p-NW)*ASIZE +: ASIZE]);
  endfunction
  function automatic bit p_load(int p);
    return (p < NW) ? bit'(WR_LOAD[p]) : bit'(RD_LOAD[p-NW]);
  endfunction

  function automatic bit m_elig(int p);
    if (p_len(p) == 0 || p_load(p)) return 1'b0;
    return (p < NW) ? (p_lvl(p) >= p_len(p)) : (p_lvl(p) < p_len(p));
  endfunction

  // Winner among currently eligible ports; -1 if none.
  function automatic int m_pick(bit rr);
    int s;
    s = rr ? m_rr : 0;
    for (int k = 0; k < NP; k++)
      if (m_elig((s + k) % NP)) return (s + k) % NP;
    return -1;
  endfunction

  // A burst of port p has completed.
  function automatic void m_commit(int p, bit loaded);
    m_rr = (p + 1) % NP;
    if (loaded) m_ptr[p] = p_min(p);
    else if (m_ptr[p] < p_max(p) - longint'(p_len(p))) m_ptr[p] = m_ptr[p] + p_len(p);
    else m_ptr[p] = p_min(p);
  endfunction

  function automatic void m_reset();
    for (int p = 0; p < NP; p++) m_ptr[p] = p_min(p);
    m_rr = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input int lvl, input int len, input int mn, input int mx);
    if (p < NW) begin
      WR_LVL[p*LVL_W +: LVL_W] = LVL_W'(lvl);
      WR_LEN[p*LEN_W +: LEN_W] = LEN_W'(len);
      WR_MIN[p*ASIZE +: ASIZE] = ASIZE'(mn);
      WR_MAX[p*ASIZE +: ASIZE] = ASIZE'(mx);
    end else begin
      RD_LVL[(p-NW)*LVL_W +: LVL_W] = LVL_W'(lvl);
      RD_LEN[(p-NW)*LEN_W +: LEN_W] = LEN_W'(len);
      RD_MIN[(p-NW)*ASIZE +: ASIZE] = ASIZE'(mn);
      RD_MAX[(p-NW)*ASIZE +: ASIZE] = ASIZE'(mx);
    end
  endtask

  task automatic set_lvl(input int p, input int lvl);
    if (p < NW) WR_LVL[p*LVL_W +: LVL_W] = LVL_W'(lvl);
    else        RD_LVL[(p-NW)*LVL_W +: LVL_W] = LVL_W'(lvl);
  endtask

  task automatic set_len(input int p, input int len);
    if (p < NW) WR_LEN[p*LEN_W +: LEN_W] = LEN_W'(len);
    else        RD_LEN[(p-NW)*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic set_load(input int p, input logic v);
    if (p < NW) WR_LOAD[p] = v;
    else        RD_LOAD[p-NW] = v;
  endtask

  // One-cycle reload while the sequencer is busy, so no grant races the pulse.
  task automatic pulse_load(input int p);
    SEQ_IDLE = 1'b0;
    set_load(p, 1'b1);
    @(negedge CTRL_CLK);
    set_load(p, 1'b0);
    SEQ_IDLE = 1'b1;
    m_ptr[p] = p_min(p);
  endtask

  // Sequencer side of one burst; results left in obs_* for the caller.
  logic             obs_got, obs_stable, obs_req_wr, obs_req_rd, obs_req_after;
  int               obs_gap;
  logic [ASIZE-1:0] obs_addr;
  logic [LEN_W-1:0] obs_len;
  logic [3:0]       obs_gnt, obs_fgnt, obs_gnt_after;

  task automatic sequencer_burst(input int load_port);
    int hold;
    obs_gap = 0;
    while (!(req_wr || req_rd) && obs_gap < 40) begin
      @(negedge CTRL_CLK);
      obs_gap++;
    end
    obs_got = req_wr || req_rd;
    if (!obs_got) return;
    obs_req_wr = req_wr; obs_req_rd = req_rd;
    obs_addr = req_addr; obs_len = req_len;
    obs_gnt  = {gnt_rd, gnt_wr};
    obs_fgnt = {f_gnt_rd, f_gnt_wr};
    obs_stable = 1'b1;
    hold = $urandom_range(1, 4);
    for (int c = 0; c < hold; c++) begin
      if (c == 0 && load_port >= 0) set_load(load_port, 1'b1);
      @(negedge CTRL_CLK);
      if (c == 0 && load_port >= 0) set_load(load_port, 1'b0);
      if (req_wr !== obs_req_wr || req_rd !== obs_req_rd || req_addr !== obs_addr ||
          req_len !== obs_len || {gnt_rd, gnt_wr} !== obs_gnt) obs_stable = 1'b0;
    end
    XFER_DONE = 1'b1;
    @(negedge CTRL_CLK);
    XFER_DONE = 1'b0;
    obs_req_after = req_wr | req_rd;
    obs_gnt_after = {gnt_rd, gnt_wr};
  endtask

  task automatic init_inputs();
    WR_LOAD = '0; RD_LOAD = '0; SEQ_IDLE = 1'b1; XFER_DONE = 1'b0;
    set_port(0, 0,   256, 'h0000, 'h0400);
    set_port(1, 0,   256, 'h1000, 'h1400);
    set_port(2, 400, 256, 'h2000, 'h2400);
    set_port(3, 400, 256, 'h3000, 'h3400);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge CTRL_CLK);
    n_checks++; if ({req_wr, req_rd} !== 2'b00) begin n_errors++; $display("FAIL reset_req: got %b expected 00", {req_wr, req_rd}); end
    n_checks++; if ({gnt_rd, gnt_wr} !== 4'h0) begin n_errors++; $display("FAIL reset_gnt: got %h expected 0", {gnt_rd, gnt_wr}); end
    n_checks++; if (req_addr !== '0 || req_len !== '0) begin n_errors++; $display("FAIL reset_addr_len: got %h/%h expected 0/0", req_addr, req_len); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    RESET_N = 1'b1;
    m_reset();
  endtask

  task automatic test_basic();
    int p;
    set_port(0, 256, 256, 0, 1024);
    for (int i = 0; i < 2; i++) begin
      p = m_pick(1);
      sequencer_burst(-1);
      n_checks++; if (obs_got !== 1'b1) begin n_errors++; $display("FAIL basic_got: got %b expected 1", obs_got); end
      n_checks++; if (obs_gap != (i == 0 ? 1 : 2)) begin n_errors++; $display("FAIL basic_latency: got %0d expected %0d", obs_gap, (i == 0 ? 1 : 2)); end
      n_checks++; if ({obs_req_wr, obs_req_rd} !== 2'b10) begin n_errors++; $display("FAIL basic_req: got %b expected 10", {obs_req_wr, obs_req_rd}); end
      n_checks++; if (obs_addr !== ASIZE'(m_ptr[p])) begin n_errors++; $display("FAIL basic_addr: got %0d expected %0d", obs_addr, m_ptr[p]); end
      n_checks++; if (obs_len !== 9'd256) begin n_errors++; $display("FAIL basic_len: got %0d expected 256", obs_len); end
      n_checks++; if (obs_gnt !== 4'b0001) begin n_errors++; $display("FAIL basic_gnt: got %b expected 0001", obs_gnt); end
      n_checks++; if (obs_req_after !== 1'b0 || obs_gnt_after !== 4'h0) begin n_errors++; $display("FAIL basic_release: got %b/%h expected 0/0", obs_req_after, obs_gnt_after); end
      m_commit(p, 1'b0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      sequencer_burst(-1);
      n_checks++; if (obs_got !== 1'b1 || obs_addr !== ASIZE'(m_ptr[0])) begin n_errors++; $display("FAIL wrap_addr: got %0d expected %0d", obs_addr, m_ptr[0]); end
      m_commit(0, 1'b0);
    end
    set_port(0, 256, 256, 64, 200);
    pulse_load(0);
    for (int i = 0; i < 2; i++) begin
      sequencer_burst(-1);
      n_checks++; if (obs_got !== 1'b1 || obs_addr !== 23'd64) begin n_errors++; $display("FAIL wrap_max_lt_len: got %0d expected 64", obs_addr); end
      m_commit(0, 1'b0);
    end
  endtask

  task automatic test_rr();
    int p, pf;
    set_port(0, 256, 256, 'h0000, 'h0400);
    set_port(1, 300, 128, 'h1000, 'h1400);
    set_port(2, 10,  256, 'h2000, 'h2400);
    set_port(3, 0,   64,  'h3000, 'h3400);
    RESET_N = 1'b0;
    @(negedge CTRL_CLK);
    RESET_N = 1'b1;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      p  = m_pick(1);
      pf = m_pick(0);
      sequencer_burst(-1);
      n_checks++; if (obs_got !== 1'b1 || obs_gnt !== 4'(1 << p)) begin n_errors++; $display("FAIL rr_order: got %b expected %b", obs_gnt, 4'(1 << p)); end
      n_checks++; if (obs_addr !== ASIZE'(m_ptr[p]) || obs_len !== LEN_W'(p_len(p))) begin n_errors++; $display("FAIL rr_addr_len: got %h/%0d expected %h/%0d", obs_addr, obs_len, m_ptr[p], p_len(p)); end
      n_checks++; if ({obs_req_wr, obs_req_rd} !== ((p < NW) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL rr_req_dir: got %b for port %0d", {obs_req_wr, obs_req_rd}, p); end
      n_checks++; if (obs_fgnt !== 4'(1 << pf)) begin n_errors++; $display("FAIL fixed_prio: got %b expected %b", obs_fgnt, 4'(1 << pf)); end
      m_commit(p, 1'b0);
    end
  endtask

  task automatic test_load_midburst();
    set_lvl(0, 0); set_lvl(1, 0); set_lvl(3, 600);
    set_port(2, 10, 256, 0, 2048);
    pulse_load(2);
    for (int i = 0; i < 4; i++) begin
      sequencer_burst(i == 2 ? 2 : -1);
      n_checks++; if (obs_got !== 1'b1 || obs_gnt !== 4'b0100) begin n_errors++; $display("FAIL load_gnt: got %b expected 0100", obs_gnt); end
      n_checks++; if (obs_addr !== ASIZE'(m_ptr[2])) begin n_errors++; $display("FAIL load_addr: got %0d expected %0d", obs_addr, m_ptr[2]); end
      n_checks++; if (obs_stable !== 1'b1 || obs_req_after !== 1'b0) begin n_errors++; $display("FAIL load_hold: got stable=%b after=%b expected 1/0", obs_stable, obs_req_after); end
      m_commit(2, i == 2);
    end
  endtask

  task automatic test_seq_busy();
    logic seen;
    longint saved;
    set_lvl(2, 600);
    set_lvl(0, 256);
    SEQ_IDLE = 1'b0;
    saved = m_ptr[0];
    seen = 1'b0;
    repeat (8) begin
      @(negedge CTRL_CLK);
      if (req_wr || req_rd) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL busy_no_req: got %b expected 0", seen); end
    XFER_DONE = 1'b1;
    @(negedge CTRL_CLK);
    XFER_DONE = 1'b0;
    SEQ_IDLE = 1'b1;
    sequencer_burst(-1);
    n_checks++; if (obs_got !== 1'b1 || obs_gap != 1) begin n_errors++; $display("FAIL busy_release: got %b gap %0d expected 1 gap 1", obs_got, obs_gap); end
    n_checks++; if (obs_addr !== ASIZE'(saved)) begin n_errors++; $display("FAIL idle_done_ptr: got %0d expected %0d", obs_addr, saved); end
    m_commit(0, 1'b0);
  endtask

  task automatic test_reset_midburst();
    int w;
    w = 0;
    while (!(req_wr || req_rd) && w < 10) begin
      @(negedge CTRL_CLK);
      w++;
    end
    n_checks++; if ((req_wr || req_rd) !== 1'b1) begin n_errors++; $display("FAIL rst_mid_grant: got %b expected 1", req_wr || req_rd); end
    #2 RESET_N = 1'b0;
    #1;
    n_checks++; if ({req_wr, req_rd, gnt_rd, gnt_wr} !== 6'h0 || req_addr !== '0) begin n_errors++; $display("FAIL rst_async: got %b/%h expected 0/0", {req_wr, req_rd, gnt_rd, gnt_wr}, req_addr); end
    @(negedge CTRL_CLK);
    RESET_N = 1'b1;
    m_reset();
    sequencer_burst(-1);
    n_checks++; if (obs_got !== 1'b1 || obs_addr !== 23'd0) begin n_errors++; $display("FAIL rst_ptr_min: got %0d expected 0", obs_addr); end
    m_commit(0, 1'b0);
  endtask

  task automatic test_random();
    int p, pf, lp;
    logic seen;
    for (int q = 0; q < NP; q++) begin
      set_port(q, 0, 0, q * 'h10000, q * 'h10000 + $urandom_range(200, 5000));
      pulse_load(q);
    end
    for (int it = 0; it < 60; it++) begin
      for (int q = 0; q < NP; q++) begin
        set_len(q, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 511));
        set_lvl(q, $urandom_range(0, 600));
      end
      if ($urandom_range(0, 3) == 0) pulse_load($urandom_range(0, NP - 1));
      p  = m_pick(1);
      pf = m_pick(0);
      if (p < 0) begin
        seen = 1'b0;
        repeat (4) begin
          @(negedge CTRL_CLK);
          if (req_wr || req_rd) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rand_none: got req %b expected 0", seen); end
      end else begin
        lp = ($urandom_range(0, 4) == 0) ? p : -1;
        sequencer_burst(lp);
        n_checks++; if (obs_got !== 1'b1 || obs_gnt !== 4'(1 << p)) begin n_errors++; $display("FAIL rand_gnt: got %b expected %b", obs_gnt, 4'(1 << p)); end
        n_checks++; if (obs_addr !== ASIZE'(m_ptr[p]) || obs_len !== LEN_W'(p_len(p))) begin n_errors++; $display("FAIL rand_addr_len: got %h/%0d expected %h/%0d", obs_addr, obs_len, m_ptr[p], p_len(p)); end
        n_checks++; if (obs_fgnt !== 4'(1 << pf)) begin n_errors++; $display("FAIL rand_fixed: got %b expected %b", obs_fgnt, 4'(1 << pf)); end
        m_commit(p, lp >= 0);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    init_inputs();
    test_reset();
    test_basic();
    test_wrap();
    test_rr();
    test_load_midburst();
    test_seq_busy();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
